// File: rtl/screen_to_frame_locator_if.sv
// Pixel bus between the VGA timing counter and the renderers: scan position in,
// game-frame coordinate, tile and per-frame pixel statistics out.
interface screen_to_frame_locator_if;
    // Handshake: pix_valid qualifies x_screen/y_screen/frame_start each cycle and
    // out_valid qualifies the outputs; there is no backpressure (no ready), one pixel per clock.
    logic        frame_start;
    logic        pix_valid;
    logic [9:0]  x_screen;
    logic [9:0]  y_screen;
    logic        out_valid;
    logic        in_frame;
    logic [8:0]  x_frame;
    logic [8:0]  y_frame;
    logic [4:0]  tile_col;
    logic [4:0]  tile_row;
    logic [2:0]  sub_x;
    logic [2:0]  sub_y;
    logic [9:0]  tile_addr;
    logic        tile_new;
    logic [17:0] pix_count;
    logic [17:0] frame_pix_total;

    modport master (
        output frame_start, pix_valid, x_screen, y_screen,
        input  out_valid, in_frame, x_frame, y_frame, tile_col, tile_row,
               sub_x, sub_y, tile_addr, tile_new, pix_count, frame_pix_total
    );

    modport slave (
        input  frame_start, pix_valid, x_screen, y_screen,
        output out_valid, in_frame, x_frame, y_frame, tile_col, tile_row,
               sub_x, sub_y, tile_addr, tile_new, pix_count, frame_pix_total
    );
endinterface

// File: rtl/screen_to_frame_locator.sv
// Maps a VGA scan position back to game-frame coordinates, maze tile and pixel-in-tile,
// with tile-entry flagging and per-frame in-frame pixel counting. Two-stage pipeline.
module screen_to_frame_locator #(
    parameter int X_ORIGIN   = 180,
    parameter int Y_ORIGIN   = 379,
    parameter int FRAME_W    = 224,
    parameter int FRAME_H    = 248,
    parameter int TILE_SHIFT = 3,
    parameter int TILE_COLS  = 28
) (
    input  logic                        clk,
    input  logic                        reset,
    screen_to_frame_locator_if.slave    bus
);

    localparam logic [17:0] COUNT_MAX = '1;

    // Stage 1: signed offsets; the 11-bit width keeps negative dx/dy from aliasing into range.
    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_x;
    logic        in_y;
    logic        in_frame_c;

    assign dx         = {1'b0, bus.x_screen} - 11'(X_ORIGIN);
    assign dy         = 11'(Y_ORIGIN) - {1'b0, bus.y_screen};
    assign in_x       = !dx[10] && (dx < 11'(FRAME_W));
    assign in_y       = !dy[10] && (dy < 11'(FRAME_H));
    assign in_frame_c = bus.pix_valid && in_x && in_y;

    logic       valid_s1;
    logic       fs_s1;
    logic       in_s1;
    logic [8:0] x_s1;
    logic [8:0] y_s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_s1 <= 1'b0;
            fs_s1    <= 1'b0;
            in_s1    <= 1'b0;
            x_s1     <= '0;
            y_s1     <= '0;
        end else begin
            valid_s1 <= bus.pix_valid;
            fs_s1    <= bus.frame_start;
            in_s1    <= in_frame_c;
            x_s1     <= in_frame_c ? dx[8:0] : 9'd0;
            y_s1     <= in_frame_c ? dy[8:0] : 9'd0;
        end
    end

    // Stage 2 combinational decode of the stage-1 coordinate.
    logic [4:0] col_c;
    logic [4:0] row_c;
    logic [2:0] sub_x_c;
    logic [2:0] sub_y_c;
    logic [9:0] addr_c;

    assign col_c   = 5'(x_s1 >> TILE_SHIFT);
    assign row_c   = 5'(y_s1 >> TILE_SHIFT);
    assign sub_x_c = 3'(x_s1);
    assign sub_y_c = 3'(y_s1);
    assign addr_c  = 10'(row_c * TILE_COLS) + 10'(col_c);

    // History of the last valid pixel; a frame start makes the history look empty.
    logic       hist_in;
    logic [4:0] hist_col;
    logic [4:0] hist_row;
    logic       tile_new_c;

    assign tile_new_c = valid_s1 && in_s1 &&
                        (fs_s1 || !hist_in || (col_c != hist_col) || (row_c != hist_row));

    logic        out_valid_r;
    logic        in_frame_r;
    logic [8:0]  x_frame_r;
    logic [8:0]  y_frame_r;
    logic [4:0]  tile_col_r;
    logic [4:0]  tile_row_r;
    logic [2:0]  sub_x_r;
    logic [2:0]  sub_y_r;
    logic [9:0]  tile_addr_r;
    logic        tile_new_r;
    logic [17:0] pix_count_r;
    logic [17:0] frame_total_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r   <= 1'b0;
            in_frame_r    <= 1'b0;
            x_frame_r     <= '0;
            y_frame_r     <= '0;
            tile_col_r    <= '0;
            tile_row_r    <= '0;
            sub_x_r       <= '0;
            sub_y_r       <= '0;
            tile_addr_r   <= '0;
            tile_new_r    <= 1'b0;
            hist_in       <= 1'b0;
            hist_col      <= '0;
            hist_row      <= '0;
            pix_count_r   <= '0;
            frame_total_r <= '0;
        end else begin
            out_valid_r <= valid_s1;
            if (valid_s1) begin
                in_frame_r  <= in_s1;
                x_frame_r   <= x_s1;
                y_frame_r   <= y_s1;
                tile_col_r  <= col_c;
                tile_row_r  <= row_c;
                sub_x_r     <= sub_x_c;
                sub_y_r     <= sub_y_c;
                tile_addr_r <= addr_c;
                tile_new_r  <= tile_new_c;
                hist_in     <= in_s1;
                hist_col    <= col_c;
                hist_row    <= row_c;
            end else if (fs_s1) begin
                hist_in <= 1'b0;
            end

            // Frame start wins over the increment; the count saturates rather than wrapping.
            if (fs_s1) begin
                frame_total_r <= pix_count_r;
                pix_count_r   <= (valid_s1 && in_s1) ? 18'd1 : 18'd0;
            end else if (valid_s1 && in_s1 && (pix_count_r != COUNT_MAX)) begin
                pix_count_r <= pix_count_r + 18'd1;
            end
        end
    end

    assign bus.out_valid       = out_valid_r;
    assign bus.in_frame        = in_frame_r;
    assign bus.x_frame         = x_frame_r;
    assign bus.y_frame         = y_frame_r;
    assign bus.tile_col        = tile_col_r;
    assign bus.tile_row        = tile_row_r;
    assign bus.sub_x           = sub_x_r;
    assign bus.sub_y           = sub_y_r;
    assign bus.tile_addr       = tile_addr_r;
    assign bus.tile_new        = tile_new_r;
    assign bus.pix_count       = pix_count_r;
    assign bus.frame_pix_total = frame_total_r;

endmodule

// File: tb/tb_screen_to_frame_locator.sv
// Bench for screen_to_frame_locator: directed pixels and scans drive the bus, a queue holds
// expected outputs and a negedge monitor compares them as out_valid appears.
module tb_screen_to_frame_locator;

    logic clk;
    logic reset;

    screen_to_frame_locator_if bus ();

    screen_to_frame_locator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed result: {in, x9, y9, col5, row5, sx3, sy3, addr10, tile_new, count18, total18}
    localparam int W = 82;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           vectors     = 0;
    int           miscompares = 0;
    int           tn_seen     = 0;

    // Reference state of the bench's own model
    int m_hist_in, m_hist_col, m_hist_row, m_count, m_total;

    function automatic logic [W-1:0] pack(input int in_f, input int xf, input int yf,
                                          input int col, input int row, input int sx, input int sy,
                                          input int addr, input int tn, input int cnt, input int tot);
        return {1'(in_f), 9'(xf), 9'(yf), 5'(col), 5'(row), 3'(sx), 3'(sy),
                10'(addr), 1'(tn), 18'(cnt), 18'(tot)};
    endfunction

    function automatic void model_reset();
        m_hist_in = 0; m_hist_col = 0; m_hist_row = 0; m_count = 0; m_total = 0;
    endfunction

    task automatic drive(input bit fs, input bit v, input int x, input int y,
                         input bit hand, input logic [W-1:0] hexp, input string name);
        int dx, dy, inf, xf, yf, col, row, tn;
        logic [W-1:0] m;
        @(posedge clk);
        #1;
        bus.frame_start = fs;
        bus.pix_valid   = v;
        bus.x_screen    = 10'(x);
        bus.y_screen    = 10'(y);
        dx  = x - 180;
        dy  = 379 - y;
        inf = (v && dx >= 0 && dx < 224 && dy >= 0 && dy < 248) ? 1 : 0;
        xf  = inf ? dx : 0;
        yf  = inf ? dy : 0;
        col = xf / 8;
        row = yf / 8;
        if (fs) m_hist_in = 0;
        tn = (v && inf && (!m_hist_in || col != m_hist_col || row != m_hist_row)) ? 1 : 0;
        if (v) begin
            m_hist_in = inf; m_hist_col = col; m_hist_row = row;
        end
        if (fs) begin
            m_total = m_count;
            m_count = inf;
        end else if (inf && m_count < 262143) begin
            m_count++;
        end
        m = pack(inf, xf, yf, col, row, xf % 8, yf % 8, row * 28 + col, tn, m_count, m_total);
        if (v) begin
            exp_q.push_back(hand ? hexp : m);
            name_q.push_back(name);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0, '0, "idle");
    endtask

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] observed();
        return {bus.in_frame, bus.x_frame, bus.y_frame, bus.tile_col, bus.tile_row,
                bus.sub_x, bus.sub_y, bus.tile_addr, bus.tile_new, bus.pix_count,
                bus.frame_pix_total};
    endfunction

    // Monitor: pops one expectation per presented output
    initial begin
        logic [W-1:0] e;
        string        n;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && bus.out_valid === 1'b1) begin
                if (bus.tile_new === 1'b1) tn_seen++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out_valid: got out_valid=1, expected no output");
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    check(n, {1'b0, observed()}, {1'b0, e});
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        reset           = 1'b1;
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.x_screen    = '0;
        bus.y_screen    = '0;

        // Reset held 3 cycles with random inputs
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.frame_start = 1'($urandom_range(0, 1));
            bus.pix_valid   = 1'($urandom_range(0, 1));
            bus.x_screen    = 10'($urandom_range(0, 1023));
            bus.y_screen    = 10'($urandom_range(0, 1023));
        end
        @(negedge clk);
        check("reset_out_valid", {82'd0, bus.out_valid}, '0);
        check("reset_outputs", {1'b0, observed()}, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.pix_valid = 1'b0;
        bus.frame_start = 1'b0;

        // Directed corners
        drive(0, 1, 180, 379, 1, pack(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), "origin");
        drive(0, 1, 403, 132, 1, pack(1, 223, 247, 27, 30, 7, 7, 867, 1, 2, 0), "far_corner");
        drive(0, 1, 179, 379, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), "left_of_frame");
        drive(0, 1, 404, 300, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), "right_of_frame");
        drive(0, 1, 200, 380, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), "below_frame");
        drive(0, 1, 200, 131, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), "above_frame");
        idle(3);

        // Scanline across the bottom frame row: 28 tile entries expected
        tn_seen = 0;
        for (int x = 170; x <= 420; x++) drive(0, 1, x, 379, 0, '0, "scanline");
        idle(3);
        check("scanline_tile_new_pulses", (W+1)'(tn_seen), (W+1)'(28));

        // One frame over the frame window plus a 1-pixel margin, then the next frame start
        for (int y = 131; y <= 380; y++)
            for (int x = 179; x <= 404; x++)
                drive((y == 131 && x == 179), 1, x, y, 0, '0, "frame_scan");
        drive(1, 1, 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 55552), "frame_total");
        drive(0, 1, 180, 379, 1, pack(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 55552), "count_restart");
        drive(1, 0, 0, 0, 0, '0, "fs_no_pixel");
        drive(0, 1, 180, 379, 1, pack(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), "fs_clears_history");
        idle(3);

        // Reset in the middle of a scanline
        for (int x = 170; x < 200; x++) drive(0, 1, x, 300, 0, '0, "pre_reset_scan");
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.pix_valid = 1'b0;
        bus.frame_start = 1'b0;
        @(negedge clk);
        #1;
        exp_q.delete();
        name_q.delete();
        model_reset();
        @(negedge clk);
        check("reset_drops_out_valid", {82'd0, bus.out_valid}, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 1, 190, 300, 1, pack(1, 10, 79, 1, 9, 2, 7, 253, 1, 1, 0), "post_reset_pixel");
        idle(4);

        check("queue_drained", (W+1)'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
